// File: rtl/move_core_pkg.sv
// Shared definitions for the move-only core: SPR numbering, instruction
// field positions derived from the data width, and the ALU operation type.
package move_core_pkg;

  localparam logic [4:0] SPR_PC   = 5'd0;
  localparam logic [4:0] SPR_A    = 5'd1;
  localparam logic [4:0] SPR_ADD  = 5'd2;
  localparam logic [4:0] SPR_SUB  = 5'd3;
  localparam logic [4:0] SPR_R    = 5'd4;
  localparam logic [4:0] SPR_FLAG = 5'd5;
  localparam logic [4:0] SPR_OUT  = 5'd6;
  localparam logic [4:0] SPR_IN   = 5'd7;
  localparam logic [4:0] SPR_HALT = 5'd8;

  localparam int SRC_LSB = 6;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  function automatic int t_bit(input int data_w);
    return data_w + 7;
  endfunction

  function automatic int c_bit(input int data_w);
    return data_w + 6;
  endfunction

  function automatic int src_msb(input int data_w);
    return data_w + 5;
  endfunction

endpackage

// File: rtl/move_core_regfile.sv
// General-purpose register file: one combinational read port, one synchronous
// write port. Indices at or above GPR_COUNT read as zero and ignore writes.
module move_core_regfile #(
  parameter int DATA_W    = 32,
  parameter int GPR_COUNT = 32
) (
  input  logic              i_clk,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int IDX_W = (GPR_COUNT > 1) ? $clog2(GPR_COUNT) : 1;

  logic [DATA_W-1:0] mem [GPR_COUNT];
  logic              waddr_ok;
  logic              raddr_ok;

  assign waddr_ok = int'(waddr) < GPR_COUNT;
  assign raddr_ok = int'(raddr) < GPR_COUNT;

  // NOTE: storage arrays get no reset so they map onto plain RAM/flops without
  // a reset tree; software must write a GPR before reading it.
  always_ff @(posedge i_clk) begin
    if (we && waddr_ok) mem[waddr[IDX_W-1:0]] <= wdata;
  end

  assign rdata = raddr_ok ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/move_core_pipe.sv
// Two-stage move-only core: F presents the fetch address, E decodes one
// source->destination move from the returned word and commits it at the edge.
module move_core_pipe
  import move_core_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int GPR_COUNT = 32,
  parameter int PC_W      = 8,
  parameter int RESET_PC  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic [DATA_W+7:0] i_imem_data,
  input  logic [DATA_W-1:0] i_in_data,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  output logic              o_halted,
  output logic [PC_W-1:0]   o_pc
);
  localparam int              T_BIT   = t_bit(DATA_W);
  localparam int              C_BIT   = c_bit(DATA_W);
  localparam int              SRC_MSB = src_msb(DATA_W);
  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   e_pc;
  logic              e_valid;
  logic              halted;
  logic              flag;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  logic              is_reg;
  logic              is_cond;
  logic [DATA_W-1:0] src_lit;
  logic [5:0]        src_addr;
  logic [5:0]        dst;
  logic              exec;
  logic              spr_we;
  logic              take_jump;
  logic              do_halt;
  logic [DATA_W-1:0] gpr_rdata;
  logic [DATA_W-1:0] spr_rdata;
  logic [DATA_W-1:0] src_val;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_res;

  assign is_reg   = i_imem_data[T_BIT];
  assign is_cond  = i_imem_data[C_BIT];
  assign src_lit  = i_imem_data[SRC_MSB:SRC_LSB];
  assign src_addr = i_imem_data[SRC_LSB+5:SRC_LSB];
  assign dst      = i_imem_data[5:0];

  // A cancelled conditional still occupies its E slot but commits nothing.
  assign exec      = e_valid && !(is_cond && !flag);
  assign spr_we    = exec && !dst[5];
  assign take_jump = spr_we && (dst[4:0] == SPR_PC);
  assign do_halt   = spr_we && (dst[4:0] == SPR_HALT);

  move_core_regfile #(
    .DATA_W   (DATA_W),
    .GPR_COUNT(GPR_COUNT)
  ) u_regfile (
    .i_clk(i_clk),
    .we   (exec && dst[5]),
    .waddr(dst[4:0]),
    .wdata(src_val),
    .raddr(src_addr[4:0]),
    .rdata(gpr_rdata)
  );

  // NOTE: every combinational output gets a default before the case so that
  // unlisted selector values cannot infer a latch.
  always_comb begin
    spr_rdata = '0;
    case (src_addr[4:0])
      SPR_PC:   spr_rdata = DATA_W'(e_pc);
      SPR_A:    spr_rdata = alu_a;
      SPR_R:    spr_rdata = alu_r;
      SPR_FLAG: spr_rdata = DATA_W'(flag);
      SPR_IN:   spr_rdata = i_in_data;
      default:  spr_rdata = '0;
    endcase
  end

  assign src_val = !is_reg    ? src_lit :
                   src_addr[5] ? gpr_rdata : spr_rdata;

  assign alu_op  = (dst[4:0] == SPR_SUB) ? ALU_SUB : ALU_ADD;
  assign alu_res = (alu_op == ALU_SUB) ? alu_a - src_val : alu_a + src_val;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc        <= PC_INIT;
      e_pc      <= PC_INIT;
      e_valid   <= 1'b0;
      halted    <= 1'b0;
      flag      <= 1'b0;
      alu_a     <= '0;
      alu_r     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (halted || do_halt) begin
        halted  <= 1'b1;
        e_valid <= 1'b0;
      end else if (take_jump) begin
        // The word fetched behind the jump is squashed by dropping e_valid.
        pc      <= src_val[PC_W-1:0];
        e_valid <= 1'b0;
      end else begin
        pc      <= pc + PC_W'(1);
        e_pc    <= pc;
        e_valid <= 1'b1;
      end

      if (spr_we) begin
        case (dst[4:0])
          SPR_A:            alu_a <= src_val;
          SPR_ADD, SPR_SUB: alu_r <= alu_res;
          SPR_FLAG:         flag  <= |src_val;
          SPR_OUT: begin
            out_data  <= src_val;
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_imem_addr = pc;
  assign o_pc        = pc;
  assign o_out_data  = out_data;
  assign o_out_valid = out_valid;
  assign o_halted    = halted;

endmodule

// File: tb/tb_move_core_pipe.sv
// Self-checking bench for move_core_pipe: directed program table, hand-written
// jump/halt/reset sequences, and random programs against an ISA-level model.
module tb_move_core_pipe;
  localparam int DATA_W    = 8;
  localparam int GPR_COUNT = 16;
  localparam int PC_W      = 8;
  localparam int IW        = DATA_W + 8;

  localparam logic [5:0] D_PC   = 6'd0;
  localparam logic [5:0] D_A    = 6'd1;
  localparam logic [5:0] D_ADD  = 6'd2;
  localparam logic [5:0] D_SUB  = 6'd3;
  localparam logic [5:0] D_R    = 6'd4;
  localparam logic [5:0] D_FLAG = 6'd5;
  localparam logic [5:0] D_OUT  = 6'd6;
  localparam logic [5:0] D_IN   = 6'd7;
  localparam logic [5:0] D_HALT = 6'd8;
  localparam logic [5:0] D_NONE = 6'd9;

  localparam logic [15:0] HALT_I = {2'b00, 8'h00, 6'd8};
  localparam logic [15:0] NOP_I  = {2'b00, 8'h00, 6'd9};

  logic              i_clk   = 1'b0;
  logic              i_rst_n = 1'b1;
  logic [PC_W-1:0]   o_imem_addr;
  logic [IW-1:0]     i_imem_data;
  logic [DATA_W-1:0] i_in_data = '0;
  logic [DATA_W-1:0] o_out_data;
  logic              o_out_valid;
  logic              o_halted;
  logic [PC_W-1:0]   o_pc;

  logic [IW-1:0] rom [256];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) i_imem_data <= rom[o_imem_addr];

  move_core_pipe #(
    .DATA_W   (DATA_W),
    .GPR_COUNT(GPR_COUNT),
    .PC_W     (PC_W),
    .RESET_PC (0)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_imem_addr(o_imem_addr),
    .i_imem_data(i_imem_data),
    .i_in_data  (i_in_data),
    .o_out_data (o_out_data),
    .o_out_valid(o_out_valid),
    .o_halted   (o_halted),
    .o_pc       (o_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction encoders.
  function automatic logic [15:0] lit(input logic [7:0] v, input logic [5:0] d);
    return {2'b00, v, d};
  endfunction
  function automatic logic [15:0] clit(input logic [7:0] v, input logic [5:0] d);
    return {2'b01, v, d};
  endfunction
  function automatic logic [15:0] mv(input logic [5:0] s, input logic [5:0] d);
    return {2'b10, 2'b00, s, d};
  endfunction
  function automatic logic [5:0] g(input int n);
    return 6'(32 + n);
  endfunction

  // Output monitor: cycle k = sample just after the k-th edge since release.
  int           cyc;
  logic [7:0]   oq_v [$];
  int           oq_c [$];
  logic [7:0]   pc_hist [256];

  always @(negedge i_clk) begin
    if (!i_rst_n) cyc = 0;
    else begin
      cyc = cyc + 1;
      if (cyc < 256) pc_hist[cyc] = o_pc;
      if (o_out_valid) begin
        oq_v.push_back(o_out_data);
        oq_c.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    oq_v.delete();
    oq_c.delete();
    #1 i_rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = HALT_I;
  endtask

  // ISA-level reference: steps architectural instructions, charging one cycle
  // per instruction and one extra cycle per taken jump.
  logic [7:0] eq_v [$];
  int         eq_c [$];
  bit         m_halted;
  int         m_pc;

  task automatic model_run(input int max_cyc, input logic [7:0] in_val);
    int         pc, t;
    logic [15:0] w;
    logic [7:0] v, a, r;
    logic [5:0] s, d;
    bit         flag;
    logic [7:0] gr [16];
    pc = 0; t = 2; a = 0; r = 0; flag = 0; m_halted = 0; m_pc = 0;
    for (int i = 0; i < 16; i++) gr[i] = 0;
    eq_v.delete(); eq_c.delete();
    while (t <= max_cyc) begin
      w = rom[pc];
      s = w[11:6];
      d = w[5:0];
      if (w[14] && !flag) begin
        pc = (pc + 1) % 256; t++;
        continue;
      end
      if (!w[15]) v = w[13:6];
      else if (s[5]) v = (s[4:0] < 16) ? gr[s[3:0]] : 8'h00;
      else begin
        case (s[4:0])
          5'd0:    v = 8'(pc);
          5'd1:    v = a;
          5'd4:    v = r;
          5'd5:    v = {7'b0, flag};
          5'd7:    v = in_val;
          default: v = 8'h00;
        endcase
      end
      if (d[5]) begin
        if (d[4:0] < 16) gr[d[3:0]] = v;
      end else begin
        case (d[4:0])
          5'd0: begin pc = v; t += 2; continue; end
          5'd1: a = v;
          5'd2: r = a + v;
          5'd3: r = a - v;
          5'd5: flag = (v != 0);
          5'd6: begin eq_v.push_back(v); eq_c.push_back(t); end
          5'd8: begin m_halted = 1; m_pc = (pc + 1) % 256; break; end
          default: ;
        endcase
      end
      pc = (pc + 1) % 256; t++;
    end
  endtask

  task automatic compare_model(input string nm, input int max_cyc);
    model_run(max_cyc, i_in_data);
    check($sformatf("%s out_count", nm), oq_v.size(), eq_v.size());
    for (int i = 0; i < eq_v.size(); i++) begin
      if (i < oq_v.size()) begin
        check($sformatf("%s out%0d_value", nm, i), oq_v[i], eq_v[i]);
        check($sformatf("%s out%0d_cycle", nm, i), oq_c[i], eq_c[i]);
      end
    end
    check($sformatf("%s halted", nm), o_halted, m_halted);
    if (m_halted) check($sformatf("%s frozen_pc", nm), o_pc, m_pc);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [5:0] s, d;
    logic       c;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: s = g($urandom_range(0, 17));
      4:          s = D_A;
      5:          s = D_R;
      6:          s = D_FLAG;
      7:          s = D_IN;
      8:          s = D_PC;
      default:    s = D_ADD;
    endcase
    case ($urandom_range(0, 15))
      0, 1, 2, 3:  d = g($urandom_range(0, 17));
      4, 5:        d = D_A;
      6, 7:        d = D_ADD;
      8:           d = D_SUB;
      9, 10:       d = D_FLAG;
      11, 12, 13:  d = D_OUT;
      14:          d = D_NONE;
      default:     d = D_PC;
    endcase
    c = ($urandom_range(0, 3) == 0);
    if (d == D_PC) return {1'b0, c, 8'($urandom_range(16, 40)), D_PC};
    if ($urandom_range(0, 1) == 1) return {1'b1, c, 2'b00, s, d};
    return {1'b0, c, 8'($urandom), d};
  endfunction

  // Directed program table.
  typedef struct {
    string             name;
    logic [7:0][15:0]  prog;
    logic [7:0]        in_val;
    int                exp_cnt;
    logic [7:0]        exp_out;
    int                exp_cyc;
  } vec_t;

  vec_t        vecs [$];
  logic [15:0] p [8];

  task automatic clr_p();
    for (int i = 0; i < 8; i++) p[i] = HALT_I;
  endtask

  task automatic add_vec(input string nm, input logic [7:0] inv, input int cnt,
                         input logic [7:0] eo, input int ec);
    vec_t v;
    v.name = nm; v.in_val = inv; v.exp_cnt = cnt; v.exp_out = eo; v.exp_cyc = ec;
    for (int i = 0; i < 8; i++) v.prog[i] = p[i];
    vecs.push_back(v);
  endtask

  initial begin
    // Async reset with no clock edge needed.
    #2 i_rst_n = 1'b0;
    #1;
    check("reset pc", o_pc, 0);
    check("reset imem_addr", o_imem_addr, 0);
    check("reset out_data", o_out_data, 0);
    check("reset out_valid", o_out_valid, 0);
    check("reset halted", o_halted, 0);

    clr_p(); p[0] = lit(8'h05, g(3)); p[1] = mv(g(3), D_OUT);
    add_vec("lit_move", 8'h00, 1, 8'h05, 3);
    clr_p(); p[0] = lit(8'hFF, D_A); p[1] = lit(8'h02, D_ADD); p[2] = mv(D_R, D_OUT);
    add_vec("add_wrap", 8'h00, 1, 8'h01, 4);
    clr_p(); p[0] = lit(8'h00, D_A); p[1] = lit(8'h01, D_SUB); p[2] = mv(D_R, D_OUT);
    add_vec("sub_wrap", 8'h00, 1, 8'hFF, 4);
    clr_p(); p[0] = lit(8'h03, D_A); p[1] = lit(8'h04, D_ADD); p[2] = lit(8'h09, D_A);
    p[3] = mv(D_R, D_OUT);
    add_vec("r_held", 8'h00, 1, 8'h07, 5);
    clr_p(); p[0] = lit(8'h00, D_FLAG); p[1] = clit(8'h07, D_OUT);
    add_vec("cond_skip", 8'h00, 0, 8'h00, 0);
    clr_p(); p[0] = lit(8'h01, D_FLAG); p[1] = clit(8'h07, D_OUT);
    add_vec("cond_take", 8'h00, 1, 8'h07, 3);
    clr_p(); p[0] = mv(D_IN, D_OUT);
    add_vec("in_read", 8'hA5, 1, 8'hA5, 2);
    clr_p(); for (int i = 0; i < 6; i++) p[i] = NOP_I; p[6] = mv(D_PC, D_OUT);
    add_vec("pc_read", 8'h00, 1, 8'h06, 8);
    clr_p(); p[0] = lit(8'h80, D_FLAG); p[1] = mv(D_FLAG, D_OUT);
    add_vec("flag_or", 8'h00, 1, 8'h01, 3);
    clr_p(); p[0] = lit(8'h01, D_FLAG); p[1] = clit(8'h00, D_FLAG); p[2] = clit(8'h09, D_OUT);
    p[3] = mv(D_FLAG, D_OUT);
    add_vec("flag_old", 8'h00, 1, 8'h00, 5);
    clr_p(); p[0] = lit(8'h03, g(15)); p[1] = mv(g(15), D_OUT);
    add_vec("gpr_top", 8'h00, 1, 8'h03, 3);
    clr_p(); p[0] = lit(8'h07, g(16)); p[1] = mv(g(16), D_OUT);
    add_vec("gpr_oob", 8'h00, 1, 8'h00, 3);
    clr_p(); p[0] = lit(8'h04, D_PC); p[1] = lit(8'h99, D_OUT); p[4] = lit(8'h42, D_OUT);
    add_vec("jump_short", 8'h00, 1, 8'h42, 4);

    foreach (vecs[k]) begin
      clear_rom();
      for (int a = 0; a < 8; a++) rom[a] = vecs[k].prog[a];
      i_in_data = vecs[k].in_val;
      do_reset();
      run(30);
      check($sformatf("%s out_count", vecs[k].name), oq_v.size(), vecs[k].exp_cnt);
      if (vecs[k].exp_cnt > 0 && oq_v.size() > 0) begin
        check($sformatf("%s out_value", vecs[k].name), oq_v[0], vecs[k].exp_out);
        check($sformatf("%s out_cycle", vecs[k].name), oq_c[0], vecs[k].exp_cyc);
      end
      check($sformatf("%s halted", vecs[k].name), o_halted, 1);
    end

    // Jump flush: the word behind the jump must never execute.
    clear_rom();
    for (int a = 0; a < 4; a++) rom[a] = NOP_I;
    rom[4] = lit(8'd10, D_PC);
    rom[5] = lit(8'h99, D_OUT);
    rom[10] = lit(8'h11, D_OUT);
    rom[11] = lit(8'h22, D_OUT);
    do_reset();
    run(30);
    check("jump pc_after_jump", pc_hist[6], 10);
    check("jump pc_next", pc_hist[7], 11);
    check("jump out_count", oq_v.size(), 2);
    if (oq_v.size() > 0) begin
      check("jump first_out", oq_v[0], 8'h11);
      check("jump first_cycle", oq_c[0], 8);
    end
    compare_model("jump_model", 30);

    // Jump to self: fetch PC alternates with a one-bubble period.
    clear_rom();
    rom[0] = NOP_I; rom[1] = NOP_I; rom[2] = lit(8'd2, D_PC);
    do_reset();
    run(50);
    check("self_loop pc_even", pc_hist[40], 2);
    check("self_loop pc_odd", pc_hist[41], 3);
    check("self_loop not_halted", o_halted, 0);

    // Halt, freeze, then asynchronous reset mid-cycle and restart.
    clear_rom();
    rom[0] = lit(8'h5A, D_OUT); rom[1] = NOP_I; rom[2] = NOP_I;
    rom[3] = HALT_I; rom[4] = lit(8'h99, D_OUT); rom[5] = lit(8'h77, D_OUT);
    do_reset();
    run(6);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt halted_c%0d", i), o_halted, 1);
      check($sformatf("halt pc_c%0d", i), o_pc, 4);
      run(1);
    end
    check("halt out_count", oq_v.size(), 1);
    check("halt out_data_held", o_out_data, 8'h5A);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst halted", o_halted, 0);
    check("async_rst pc", o_pc, 0);
    check("async_rst imem_addr", o_imem_addr, 0);
    check("async_rst out_data", o_out_data, 0);
    check("async_rst out_valid", o_out_valid, 0);
    do_reset();
    run(10);
    check("restart out_count", oq_v.size(), 1);
    if (oq_v.size() > 0) begin
      check("restart out_value", oq_v[0], 8'h5A);
      check("restart out_cycle", oq_c[0], 2);
    end
    check("restart halted", o_halted, 1);

    // Random programs against the ISA model.
    for (int it = 0; it < 20; it++) begin
      clear_rom();
      for (int r = 0; r < 16; r++) rom[r] = lit(8'($urandom), g(r));
      for (int a = 16; a < 40; a++) rom[a] = rand_instr();
      i_in_data = 8'($urandom);
      do_reset();
      run(150);
      compare_model($sformatf("rand%0d", it), 150);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
